// File: rtl/instr_trace_fifo_if.sv
// -----------------------------------------------------------------------------
// instr_trace_fifo_if
// Retire-record stream between the core datapath (producer) and the
// simulation instruction-table monitor (consumer), with the trace FIFO
// sitting in the middle.
//
// Signals
//   in_valid / in_*     : record offered by the core (no back-pressure)
//   out_valid / out_*   : head record presented to the monitor
//   out_ready           : monitor accepts the head record
//   out_cycle           : push-cycle stamp of the head record
//                         (present only when TRACE_CYCLE_STAMP_EN is defined)
//
// Modports
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : FIFO side (drives out_valid, out_*)
// -----------------------------------------------------------------------------
interface instr_trace_fifo_if;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [15:0] in_full_op_code;
   logic [1:0]  in_rd_data_sel;
   logic [4:0]  in_rs1_sel_zimm;
   logic [4:0]  in_rs2_sel;
   logic [4:0]  in_rd_sel;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [31:0] in_rd_data;
   logic [31:0] in_imm_csr;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [15:0] out_full_op_code;
   logic [1:0]  out_rd_data_sel;
   logic [4:0]  out_rs1_sel_zimm;
   logic [4:0]  out_rs2_sel;
   logic [4:0]  out_rd_sel;
   logic [31:0] out_rs1_data;
   logic [31:0] out_rs2_data;
   logic [31:0] out_rd_data;
   logic [31:0] out_imm_csr;
`ifdef TRACE_CYCLE_STAMP_EN
   logic [31:0] out_cycle;
`endif

   modport master (
      output in_valid, in_instr, in_full_op_code, in_rd_data_sel,
             in_rs1_sel_zimm, in_rs2_sel, in_rd_sel,
             in_rs1_data, in_rs2_data, in_rd_data, in_imm_csr,
             out_ready,
      input
`ifdef TRACE_CYCLE_STAMP_EN
             out_cycle,
`endif
             out_valid, out_instr, out_full_op_code, out_rd_data_sel,
             out_rs1_sel_zimm, out_rs2_sel, out_rd_sel,
             out_rs1_data, out_rs2_data, out_rd_data, out_imm_csr
   );

   modport slave (
      input  in_valid, in_instr, in_full_op_code, in_rd_data_sel,
             in_rs1_sel_zimm, in_rs2_sel, in_rd_sel,
             in_rs1_data, in_rs2_data, in_rd_data, in_imm_csr,
             out_ready,
      output
`ifdef TRACE_CYCLE_STAMP_EN
             out_cycle,
`endif
             out_valid, out_instr, out_full_op_code, out_rd_data_sel,
             out_rs1_sel_zimm, out_rs2_sel, out_rd_sel,
             out_rs1_data, out_rs2_data, out_rd_data, out_imm_csr
   );
endinterface

// File: rtl/instr_trace_fifo.sv
// -----------------------------------------------------------------------------
// instr_trace_fifo
// Buffers per-instruction retire records and hands them to the trace monitor
// one per handshake. The core is never stalled: a record that cannot be
// stored (FIFO full without a simultaneous pop, or flush) is dropped and
// counted in a saturating 16-bit counter.
//
// Optional feature macro: TRACE_CYCLE_STAMP_EN
//   When defined, a free-running 32-bit cycle counter stamps every pushed
//   record and the stamp is presented on tif.out_cycle.
//
// Ports
//   clk     : core clock, rising edge
//   reset   : asynchronous, active-high, clears all state
//   flush   : synchronous clear of stored entries (dropped is kept)
//   tif     : record stream (slave modport): in_* records, out_* head record
//   count   : entries stored (AW+1 bits)
//   full    : count == DEPTH
//   empty   : count == 0
//   dropped : saturating count of records lost to full/flush
// -----------------------------------------------------------------------------
module instr_trace_fifo #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   instr_trace_fifo_if.slave tif,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic [15:0]       dropped
);

   typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
      logic [31:0] cycle;
`endif
      logic [31:0] instr;
      logic [15:0] full_op_code;
      logic [1:0]  rd_data_sel;
      logic [4:0]  rs1_sel_zimm;
      logic [4:0]  rs2_sel;
      logic [4:0]  rd_sel;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] rd_data;
      logic [31:0] imm_csr;
   } entry_t;

   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

   entry_t        mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic [15:0]   dropped_r;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          drop_s;
   entry_t        wr_entry_s;
   entry_t        head_s;
`ifdef TRACE_CYCLE_STAMP_EN
   logic [31:0]   cycle_r;
`endif

   assign full_s  = (count_r == DEPTH_C);
   assign empty_s = (count_r == {(AW+1){1'b0}});
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign pop_s   = ~empty_s & tif.out_ready & ~flush;
   assign push_s  = tif.in_valid & ~flush & (~full_s | pop_s);
   assign drop_s  = tif.in_valid & ~push_s;

   assign wr_entry_s = '{
`ifdef TRACE_CYCLE_STAMP_EN
      cycle:        cycle_r,
`endif
      instr:        tif.in_instr,
      full_op_code: tif.in_full_op_code,
      rd_data_sel:  tif.in_rd_data_sel,
      rs1_sel_zimm: tif.in_rs1_sel_zimm,
      rs2_sel:      tif.in_rs2_sel,
      rd_sel:       tif.in_rd_sel,
      rs1_data:     tif.in_rs1_data,
      rs2_data:     tif.in_rs2_data,
      rd_data:      tif.in_rd_data,
      imm_csr:      tif.in_imm_csr
   };

   // Entry storage; contents need no reset because empty gates the outputs.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_entry_s;
      end
   end

   // Pointers, occupancy and the saturating drop counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {(AW+1){1'b0}};
         dropped_r <= 16'h0000;
      end else begin
         if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + CNT_ONE;
               2'b01:   count_r <= count_r - CNT_ONE;
               default: count_r <= count_r;
            endcase
         end
         if (drop_s && (dropped_r != 16'hFFFF)) begin
            dropped_r <= dropped_r + 16'd1;
         end
      end
   end

`ifdef TRACE_CYCLE_STAMP_EN
   // Free-running cycle counter used to stamp pushed records.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_r <= 32'd0;
      end else begin
         cycle_r <= cycle_r + 32'd1;
      end
   end
`endif

   // Head record read combinationally and forced to zero while empty.
   always_comb begin
      head_s = {$bits(entry_t){1'b0}};
      if (empty_s) begin
         head_s = {$bits(entry_t){1'b0}};
      end else begin
         head_s = mem_r[rd_ptr_r];
      end
   end

   assign tif.out_valid        = ~empty_s;
   assign tif.out_instr        = head_s.instr;
   assign tif.out_full_op_code = head_s.full_op_code;
   assign tif.out_rd_data_sel  = head_s.rd_data_sel;
   assign tif.out_rs1_sel_zimm = head_s.rs1_sel_zimm;
   assign tif.out_rs2_sel      = head_s.rs2_sel;
   assign tif.out_rd_sel       = head_s.rd_sel;
   assign tif.out_rs1_data     = head_s.rs1_data;
   assign tif.out_rs2_data     = head_s.rs2_data;
   assign tif.out_rd_data      = head_s.rd_data;
   assign tif.out_imm_csr      = head_s.imm_csr;
`ifdef TRACE_CYCLE_STAMP_EN
   assign tif.out_cycle        = head_s.cycle;
`endif

   assign count   = count_r;
   assign full    = full_s;
   assign empty   = empty_s;
   assign dropped = dropped_r;

endmodule
